// File: rtl/bm_rd.sv
// Bias-memory read streamer: issues credit-limited BM reads over a contiguous
// address range and replays the returned words as a valid/ready stream.
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 32
`endif
`ifndef BM_DEPTH
`define BM_DEPTH 1024
`endif

module bm_rd #(
    parameter int DATA_WIDTH = `BM_DATA_WIDTH,
    parameter int DEPTH      = `BM_DEPTH,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_pulse,
    input  logic [31:0]              c_addr,
    input  logic [31:0]              n_words,
    output logic                     busy,
    output logic                     done_pulse,
    output logic                     rd_en,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    dout,
    output logic [DATA_WIDTH-1:0]    bias_tdata,
    output logic                     bias_tvalid,
    input  logic                     bias_tready,
    output logic                     bias_tlast
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    // state | meaning
    // IDLE  | waiting for start_pulse
    // ISSUE | issuing reads while FIFO credits remain
    // DRAIN | all reads issued, waiting for the tlast handshake
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    state_t                state_next;
    logic [31:0]           remaining;
    logic [RD_LAT-1:0]     pipe_v;
    logic [RD_LAT-1:0]     pipe_l;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [DATA_WIDTH:0]   head;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;
    logic                  tlast_hs;
    logic                  accept;
    logic                  last_issue;
    logic                  done_next;
    logic                  unused_addr_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign unused_addr_bits = ^c_addr[31:AW];
    assign push        = pipe_v[RD_LAT-1];
    assign head        = fifo_mem[rd_ptr];
    assign bias_tvalid = (fifo_count != '0);
    assign bias_tdata  = bias_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign bias_tlast  = bias_tvalid & head[DATA_WIDTH];
    assign pop         = bias_tvalid & bias_tready;
    assign tlast_hs    = pop & bias_tlast;
    assign busy        = (state != IDLE);
    // Words already buffered plus reads still in the pipe must fit in the FIFO.
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            done_pulse <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        accept     = 1'b0;
        last_issue = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) begin
                    if (n_words != 32'd0) begin
                        accept     = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                rd_en      = credit_ok;
                last_issue = credit_ok && (remaining == 32'd1);
                if (last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                if (tlast_hs) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr   <= '0;
            remaining <= '0;
        end else if (accept) begin
            rd_addr   <= c_addr[AW-1:0];
            remaining <= n_words;
        end else if (rd_en) begin
            rd_addr   <= (rd_addr == AW'(DEPTH - 1)) ? '0 : rd_addr + AW'(1);
            remaining <= remaining - 32'd1;
        end
    end

    // The last flag travels with its read so tlast lands on the right word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            pipe_l <= '0;
        end else begin
            pipe_v[0] <= rd_en;
            pipe_l[0] <= last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pipe_l[RD_LAT-1], dout};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({rd_en, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_bm_rd.sv
// Self-checking bench for bm_rd: BM model with BM[i]=i, scoreboard of expected
// {tlast,data} words per command, one task per scenario.
module tb_bm_rd;
    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int LAT = 2;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_pulse;
    logic [31:0]   c_addr;
    logic [31:0]   n_words;
    logic          busy;
    logic          done_pulse;
    logic          rd_en;
    logic [3:0]    rd_addr;
    logic [DW-1:0] dout;
    logic [DW-1:0] bias_tdata;
    logic          bias_tvalid;
    logic          bias_tready;
    logic          bias_tlast;

    bm_rd #(.DATA_WIDTH(DW), .DEPTH(DEP), .RD_LAT(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .c_addr(c_addr),
        .n_words(n_words), .busy(busy), .done_pulse(done_pulse), .rd_en(rd_en),
        .rd_addr(rd_addr), .dout(dout), .bias_tdata(bias_tdata),
        .bias_tvalid(bias_tvalid), .bias_tready(bias_tready), .bias_tlast(bias_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle BM model; returns are poisoned when no read was issued.
    logic       p_v;
    logic [3:0] p_addr;
    always @(posedge clk) begin
        p_v    <= rd_en;
        p_addr <= rd_addr;
        dout   <= (p_v === 1'b1) ? {28'd0, p_addr} : 32'hDEAD_BEEF;
    end

    int errors = 0;
    int checks = 0;

    int rd_cnt, popped, first_rd, last_rd, first_tv, first_busy;
    int done_cnt, done_cyc, max_out, hold_viol, overlap;
    logic        prev_stall;
    logic [32:0] prev_word;
    logic [3:0]  rd_addrs[$];
    logic [32:0] obs_q[$];
    int          obs_cyc[$];
    logic [32:0] exp_q[$];

    task automatic clear_obs();
        rd_cnt = 0; popped = 0; first_rd = -1; last_rd = -1; first_tv = -1;
        first_busy = -1; done_cnt = 0; done_cyc = -1; max_out = 0;
        hold_viol = 0; overlap = 0; prev_stall = 1'b0; prev_word = '0;
        rd_addrs.delete(); obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    endtask

    // Observe one cycle at the falling edge, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (rd_en) begin
            rd_cnt++;
            rd_addrs.push_back(rd_addr);
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (rd_cnt - popped > max_out) max_out = rd_cnt - popped;
        if (busy && first_busy < 0) first_busy = cyc;
        if (bias_tvalid && first_tv < 0) first_tv = cyc;
        if (prev_stall && (!bias_tvalid || {bias_tlast, bias_tdata} !== prev_word)) hold_viol++;
        prev_stall = bias_tvalid && !bias_tready;
        prev_word  = {bias_tlast, bias_tdata};
        if (bias_tvalid && bias_tready) begin
            obs_q.push_back({bias_tlast, bias_tdata});
            obs_cyc.push_back(cyc);
            popped++;
        end
        if (done_pulse) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) overlap++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_pulse = 1'b0; c_addr = '0; n_words = '0; bias_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done_pulse); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b want=0", rd_en); end
        checks++; if (bias_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b want=0", bias_tvalid); end
        checks++; if (bias_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got=%b want=0", bias_tlast); end
        checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL rst_rd_addr got=%0d want=0", rd_addr); end
        checks++; if (bias_tdata !== '0) begin errors++; $display("FAIL rst_tdata got=%h want=0", bias_tdata); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_throughput();
        int ts, c;
        logic [32:0] e, g;
        clear_obs();
        bias_tready = 1'b1;
        c_addr = 32'd5; n_words = 32'd8; start_pulse = 1'b1; ts = cyc;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 32'(5 + i)});
        tick();
        start_pulse = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++; if (rd_cnt != 8) begin errors++; $display("FAIL thr_rd_count got=%0d want=8", rd_cnt); end
        checks++; if (first_rd != ts + 1) begin errors++; $display("FAIL thr_first_rd got=%0d want=%0d", first_rd - ts, 1); end
        checks++; if (last_rd != ts + 8) begin errors++; $display("FAIL thr_last_rd got=%0d want=%0d", last_rd - ts, 8); end
        checks++; if (first_busy != ts + 1) begin errors++; $display("FAIL thr_busy_rise got=%0d want=1", first_busy - ts); end
        checks++; if (first_tv != ts + 4) begin errors++; $display("FAIL thr_first_tvalid got=%0d want=4", first_tv - ts); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL thr_done_count got=%0d want=1", done_cnt); end
        checks++; if (done_cyc != ts + 12) begin errors++; $display("FAIL thr_done_cycle got=%0d want=12", done_cyc - ts); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL thr_busy_at_done got=%0d want=0", overlap); end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL thr_word%0d got=none want=%h", i, e);
            end else begin
                g = obs_q.pop_front(); c = obs_cyc.pop_front();
                if (g !== e || c != ts + 4 + i) begin
                    errors++; $display("FAIL thr_word%0d got=%h@%0d want=%h@%0d", i, g, c - ts, e, 4 + i);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL thr_extra_words got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_wrap();
        logic [32:0] e, g;
        logic [3:0]  want_a[4];
        clear_obs();
        want_a[0] = 4'd14; want_a[1] = 4'd15; want_a[2] = 4'd0; want_a[3] = 4'd1;
        bias_tready = 1'b1;
        c_addr = 32'd14; n_words = 32'd4; start_pulse = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 28'd0, want_a[i]});
        tick();
        start_pulse = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        checks++; if (rd_addrs.size() != 4) begin errors++; $display("FAIL wrap_rd_count got=%0d want=4", rd_addrs.size()); end
        for (int i = 0; i < 4 && rd_addrs.size() != 0; i++) begin
            checks++;
            if (rd_addrs[0] !== want_a[i]) begin
                errors++; $display("FAIL wrap_rd_addr%0d got=%0d want=%0d", i, rd_addrs[0], want_a[i]);
            end
            void'(rd_addrs.pop_front());
        end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : 33'h1_FFFF_FFFF;
            if (g !== e) begin errors++; $display("FAIL wrap_word%0d got=%h want=%h", i, g, e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count got=%0d want=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int rd_at20;
        logic [32:0] e, g;
        clear_obs();
        rd_at20 = -1;
        bias_tready = 1'b0;
        c_addr = 32'd2; n_words = 32'd10; start_pulse = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), 32'(2 + i)});
        tick();
        start_pulse = 1'b0;
        for (int k = 1; k < 200 && done_cnt == 0; k++) begin
            bias_tready = (k > 20) && ((k - 21) % 3 == 0);
            tick();
            if (k == 20) rd_at20 = rd_cnt;
        end
        bias_tready = 1'b1;
        repeat (3) tick();
        checks++; if (rd_at20 != 4) begin errors++; $display("FAIL bp_stalled_reads got=%0d want=4", rd_at20); end
        checks++; if (max_out != 4) begin errors++; $display("FAIL bp_max_outstanding got=%0d want=4", max_out); end
        checks++; if (rd_cnt != 10) begin errors++; $display("FAIL bp_rd_count got=%0d want=10", rd_cnt); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold_steady got=%0d want=0", hold_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : 33'h1_FFFF_FFFF;
            if (g !== e) begin errors++; $display("FAIL bp_word%0d got=%h want=%h", i, g, e); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra_words got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_zero_len();
        int ts;
        clear_obs();
        bias_tready = 1'b1;
        c_addr = 32'd7; n_words = 32'd0; start_pulse = 1'b1; ts = cyc;
        tick();
        start_pulse = 1'b0;
        repeat (6) tick();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got=%0d want=1", done_cnt); end
        checks++; if (done_cyc != ts + 1) begin errors++; $display("FAIL zero_done_cycle got=%0d want=1", done_cyc - ts); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL zero_rd_count got=%0d want=0", rd_cnt); end
        checks++; if (first_tv != -1) begin errors++; $display("FAIL zero_tvalid got=%0d want=-1", first_tv); end
        checks++; if (first_busy != -1) begin errors++; $display("FAIL zero_busy got=%0d want=-1", first_busy); end
    endtask

    task automatic test_ignored_start_and_reset();
        logic [32:0] e, g;
        // Second start mid-command must be ignored.
        clear_obs();
        bias_tready = 1'b1;
        c_addr = 32'd3; n_words = 32'd6; start_pulse = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5), 32'(3 + i)});
        tick();
        start_pulse = 1'b0;
        tick();
        c_addr = 32'd9; n_words = 32'd2; start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        repeat (14) tick();
        checks++; if (rd_cnt != 6) begin errors++; $display("FAIL ign_rd_count got=%0d want=6", rd_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_count got=%0d want=1", done_cnt); end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : 33'h1_FFFF_FFFF;
            if (g !== e) begin errors++; $display("FAIL ign_word%0d got=%h want=%h", i, g, e); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ign_extra_words got=%0d want=0", obs_q.size()); end

        // Reset with two reads in flight.
        clear_obs();
        bias_tready = 1'b0;
        c_addr = 32'd0; n_words = 32'd8; start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b want=0", busy); end
        checks++; if (done_pulse !== 1'b0) begin errors++; $display("FAIL mrst_done got=%b want=0", done_pulse); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL mrst_rd_en got=%b want=0", rd_en); end
        checks++; if (bias_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_tvalid got=%b want=0", bias_tvalid); end
        checks++; if (bias_tlast !== 1'b0) begin errors++; $display("FAIL mrst_tlast got=%b want=0", bias_tlast); end
        checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL mrst_rd_addr got=%0d want=0", rd_addr); end
        checks++; if (bias_tdata !== '0) begin errors++; $display("FAIL mrst_tdata got=%h want=0", bias_tdata); end
        @(posedge clk);
        #1;
        clear_obs();
        bias_tready = 1'b1;
        repeat (8) tick();
        checks++; if (first_tv != -1) begin errors++; $display("FAIL mrst_stale_tvalid got=%0d want=-1", first_tv); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL mrst_stale_done got=%0d want=0", done_cnt); end

        // Fresh command after reset.
        clear_obs();
        c_addr = 32'd10; n_words = 32'd3; start_pulse = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), 32'(10 + i)});
        tick();
        start_pulse = 1'b0;
        repeat (12) tick();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL fresh_done_count got=%0d want=1", done_cnt); end
        for (int i = 0; exp_q.size() != 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : 33'h1_FFFF_FFFF;
            if (g !== e) begin errors++; $display("FAIL fresh_word%0d got=%h want=%h", i, g, e); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL fresh_extra_words got=%0d want=0", obs_q.size()); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        repeat (5) tick();
        test_throughput();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_ignored_start_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
